// File: rtl/mod_final_reduce.sv
// Final modular reduction stage: turns a partially reduced value into its canonical
// residue in [0, MODULUS) plus the removed quotient, using one restoring conditional
// subtraction of (MODULUS << k) per cycle, k running from SHIFTS-1 down to 0.
module mod_final_reduce #(
  parameter int unsigned     BITS     = 392,
  parameter int unsigned     MOD_BITS = 381,
  parameter logic [BITS-1:0] MODULUS  =
    392'h1a0111ea_397fe69a_4b1ba7b6_434bacd7_64774b84_f38512bf_6730d2a0_f6b0f624_1eabfffe_b153ffff_b9feffff_ffffaaab,
  localparam int unsigned    SHIFTS   = BITS - MOD_BITS + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_val,
  output logic              o_rdy,
  input  logic [BITS-1:0]   i_dat,
  output logic              o_val,
  input  logic              i_rdy,
  output logic [BITS-1:0]   o_dat,
  output logic [SHIFTS-1:0] o_quot
);

  localparam int unsigned KW = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;

  // Pre-shifted moduli, one per step, so the datapath only needs a constant mux.
  function automatic logic [SHIFTS-1:0][BITS:0] build_table();
    logic [SHIFTS-1:0][BITS:0] t;
    for (int i = 0; i < int'(SHIFTS); i++) begin
      t[i] = {1'b0, MODULUS} << i;
    end
    return t;
  endfunction

  localparam logic [SHIFTS-1:0][BITS:0] MOD_TABLE = build_table();

  typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

  state_e            state;
  logic [BITS-1:0]   r;
  logic [SHIFTS-1:0] q;
  logic [KW-1:0]     k;

  logic [BITS:0]     diff;
  logic              take;
  logic [BITS-1:0]   r_step;
  logic [SHIFTS-1:0] q_step;

  // One restoring subtraction step; the extra top bit of diff is the borrow.
  always_comb begin
    diff      = {1'b0, r} - MOD_TABLE[k];
    take      = ~diff[BITS];
    r_step    = take ? diff[BITS-1:0] : r;
    q_step    = q;
    q_step[k] = take;
  end

  // Ready only when idle; held low for the whole cycle reset is asserted.
  always_comb begin
    o_rdy = (state == StIdle) && !i_rst;
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= StIdle;
      r      <= '0;
      q      <= '0;
      k      <= '0;
      o_val  <= 1'b0;
      o_dat  <= '0;
      o_quot <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (i_val && o_rdy) begin
            r     <= i_dat;
            q     <= '0;
            k     <= KW'(SHIFTS - 1);
            state <= StReduce;
          end
        end
        StReduce: begin
          r <= r_step;
          q <= q_step;
          if (k == '0) begin
            // Last step: publish the finished residue and quotient directly.
            state  <= StDone;
            o_val  <= 1'b1;
            o_dat  <= r_step;
            o_quot <= q_step;
          end else begin
            k <= k - KW'(1);
          end
        end
        StDone: begin
          if (i_rdy) begin
            state <= StIdle;
            o_val <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
